carregador_programa: RTL and testbench



---
 rtl/carregador_programa_if.sv | 10 +
 rtl/carregador_programa.sv | 119 +++++++++++
 tb/tb_carregador_programa.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/carregador_programa_if.sv
// carregador_programa_if: instruction-memory write port between the loader and the memory
interface carregador_programa_if #(
  parameter int ADDR_W = 10
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  modport master (output mem_we, mem_addr, mem_data);
  modport slave  (input  mem_we, mem_addr, mem_data);
endinterface

// File: rtl/carregador_programa.sv
// carregador_programa: UART program loader writing instruction memory and gating CPU reset
module carregador_programa #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10,
  parameter int MAX_WORDS    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  start,
  carregador_programa_if.master mem,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  erro
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR} state_t;
  state_t state, nxt;
  logic rx_m, rx_s, rx_d;
  logic r_act;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_idx;
  logic [7:0] r_sh;
  logic tick, stop_smp, rx_stb, rx_ferr, go;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [31:0] data, asm_w;
  logic [7:0] chk;
  logic [15:0] n, wcnt, cnt_in;
  logic [1:0] bcnt;
  assign mem.mem_we   = we;
  assign mem.mem_addr = addr;
  assign mem.mem_data = data;
  assign busy     = state inside {CNT_HI, CNT_LO, DATA, CHK};
  assign cpu_hold = busy || state == ERR;
  assign go       = start && !busy;
  assign tick     = r_act && r_cnt == (r_idx == 4'd0 ? HALF : FULL);
  assign stop_smp = tick && r_idx == 4'd9;
  assign rx_stb   = stop_smp && rx_s;
  assign rx_ferr  = stop_smp && !rx_s;
  assign cnt_in   = {n[15:8], r_sh};
  // two-flop synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge clk)
    if (reset) {rx_d, rx_s, rx_m} <= 3'b111;
    else {rx_d, rx_s, rx_m} <= {rx_s, rx_m, rx};
  // 8N1 receiver: idx 0 = start-bit recheck at half bit, 1..8 = data LSB first, 9 = stop
  always_ff @(posedge clk)
    if (reset || !busy) begin
      r_act <= 1'b0;
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!r_act) begin
      r_act <= rx_d && !rx_s;
      r_cnt <= '0;
      r_idx <= '0;
    end else if (tick) begin
      r_cnt <= '0;
      r_act <= !(r_idx == 4'd0 && rx_s) && r_idx != 4'd9;
      r_idx <= r_idx + 4'd1;
      if (r_idx != 4'd0 && r_idx != 4'd9) r_sh <= {rx_s, r_sh[7:1]};
    end else r_cnt <= r_cnt + 1'b1;
  // session state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  // frame sequencing; a framing error anywhere in the session aborts to ERR
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = go ? CNT_HI : IDLE;
      ERR:        nxt = go ? CNT_HI : ERR;
      CNT_HI:     nxt = rx_ferr ? ERR : rx_stb ? CNT_LO : CNT_HI;
      CNT_LO:     nxt = rx_ferr ? ERR : !rx_stb ? CNT_LO : cnt_in > 16'(MAX_WORDS) ? ERR : cnt_in == '0 ? CHK : DATA;
      DATA:       nxt = rx_ferr ? ERR : (we && wcnt == n) ? CHK : DATA;
      CHK:        nxt = rx_ferr ? ERR : !rx_stb ? CHK : r_sh == chk ? DONE : ERR;
      default:    nxt = IDLE;
    endcase
  end
  // count latch, word assembly, checksum, memory write port and sticky status
  always_ff @(posedge clk)
    if (reset) begin
      we    <= 1'b0;
      addr  <= '0;
      data  <= '0;
      asm_w <= '0;
      chk   <= '0;
      n     <= '0;
      wcnt  <= '0;
      bcnt  <= '0;
      done  <= 1'b0;
      erro  <= 1'b0;
    end else begin
      we <= state == DATA && rx_stb && bcnt == 2'd3;
      if (go) begin
        done <= 1'b0;
        erro <= 1'b0;
        chk  <= '0;
        wcnt <= '0;
        bcnt <= '0;
        addr <= '0;
      end
      if (state == CHK && nxt == DONE) done <= 1'b1;
      if (state != ERR && nxt == ERR) erro <= 1'b1;
      if (rx_stb && state == CNT_HI) n[15:8] <= r_sh;
      if (rx_stb && state == CNT_LO) n[7:0] <= r_sh;
      if (rx_stb && state == DATA) begin
        asm_w <= {asm_w[23:0], r_sh};
        chk   <= chk ^ r_sh;
        bcnt  <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          data <= {asm_w[23:0], r_sh};
          addr <= wcnt[ADDR_W-1:0];
          wcnt <= wcnt + 16'd1;
        end
      end
    end
endmodule

// File: tb/tb_carregador_programa.sv
// tb_carregador_programa: directed load sessions with a write scoreboard
module tb_carregador_programa;
  localparam int CPB = 16;
  localparam int AW  = 10;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, start = 1'b0;
  logic cpu_hold, busy, done, erro;
  int vectors = 0, miscompares = 0, nwr = 0, base;
  logic [AW+31:0] exp_q[$];
  logic [31:0] w0, w1, w2;
  logic [7:0] good;
  carregador_programa_if #(.ADDR_W(AW)) mem ();
  carregador_programa #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .rx(rx), .start(start), .mem(mem),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .erro(erro)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop;
    cycles(CPB);
    rx = 1'b1;
    cycles(2);
  endtask
  task automatic pulse_start;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(2);
  endtask
  task automatic send_word(input logic [31:0] w, input int a, input bit expect_write);
    if (expect_write) exp_q.push_back({AW'(a), w});
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask
  function automatic logic [7:0] xsum(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] x;
    x = a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
    return x;
  endfunction
  // every write must match the oldest expected (addr, data) pair
  always @(negedge clk)
    if (mem.mem_we === 1'b1) begin
      nwr++;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write_addr_data", 64'({mem.mem_addr, mem.mem_data}), 64'(exp_q.pop_front()));
    end
  initial begin
    w0 = 32'h2008_0005;
    w1 = 32'hAC08_0010;
    w2 = 32'h1234_5678;
    good = xsum(w0, w1);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(2);
    check("rst_busy", busy, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_erro", erro, 0);
    check("rst_we", mem.mem_we, 0);
    check("rst_addr", mem.mem_addr, 0);
    check("rst_data", mem.mem_data, 0);
    reset = 1'b0;
    cycles(10000);
    check("idle_busy", busy, 0);
    check("idle_hold", cpu_hold, 0);
    check("idle_done_erro", {done, erro}, 0);
    check("idle_writes", nwr, 0);
    pulse_start;
    check("load_busy", busy, 1);
    check("load_hold", cpu_hold, 1);
    send_byte(8'h00);
    pulse_start;
    send_byte(8'h02);
    send_word(w0, 0, 1);
    send_word(w1, 1, 1);
    send_byte(good);
    check("ok_done", done, 1);
    check("ok_erro", erro, 0);
    check("ok_hold", cpu_hold, 0);
    check("ok_busy", busy, 0);
    check("ok_writes", nwr, 2);
    check("ok_addr_hold", mem.mem_addr, 1);
    check("ok_data_hold", mem.mem_data, w1);
    pulse_start;
    check("restart_done_clr", done, 0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(w0, 0, 1);
    send_word(w1, 1, 1);
    send_byte(8'h00);
    check("badchk_erro", erro, 1);
    check("badchk_done", done, 0);
    check("badchk_hold", cpu_hold, 1);
    check("badchk_busy", busy, 0);
    check("badchk_writes", nwr, 4);
    pulse_start;
    check("err_restart_erro", erro, 0);
    check("err_restart_busy", busy, 1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(w0, 0, 1);
    send_word(w1, 1, 1);
    send_byte(good);
    check("retry_done", done, 1);
    check("retry_erro", erro, 0);
    check("retry_writes", nwr, 6);
    pulse_start;
    send_byte(8'h04);
    send_byte(8'h01);
    check("over_erro", erro, 1);
    check("over_hold", cpu_hold, 1);
    check("over_busy", busy, 0);
    pulse_start;
    send_byte(8'h04);
    send_byte(8'h00);
    check("max_busy", busy, 1);
    check("max_erro", erro, 0);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(1);
    pulse_start;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done", done, 1);
    check("zero_erro", erro, 0);
    check("zero_writes", nwr, 6);
    pulse_start;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33, 1'b0);
    check("frame_erro", erro, 1);
    check("frame_busy", busy, 0);
    send_byte(8'h44);
    check("frame_writes", nwr, 6);
    pulse_start;
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(w0, 0, 1);
    send_byte(w1[31:24]);
    send_byte(w1[23:16]);
    base = nwr;
    reset = 1'b1;
    cycles(1);
    check("abort_busy", busy, 0);
    check("abort_hold", cpu_hold, 0);
    reset = 1'b0;
    send_byte(w1[15:8]);
    send_byte(w1[7:0]);
    send_word(w2, 2, 0);
    send_byte(8'h00);
    check("abort_writes", nwr, base);
    check("abort_done_erro", {done, erro}, 0);
    check("abort_q_empty", exp_q.size(), 0);
    pulse_start;
    rx = 1'b0;
    cycles(CPB / 4);
    rx = 1'b1;
    cycles(3 * CPB);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("glitch_done", done, 1);
    check("glitch_erro", erro, 0);
    check("final_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
